// File: rtl/cog_ctrx_if.sv
// Register-access and pin bus between the cog ALU and the counter block.
interface cog_ctrx_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned PHS_W    = 32
);
    localparam int unsigned SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [SW-1:0]       sel;
    logic                setctr;
    logic                setfrq;
    logic                setphs;
    logic                rdcap;
    logic [31:0]         data;
    logic [31:0]         pin_in;
    logic [PHS_W:0]      phs_q;
    logic [PHS_W-1:0]    cap_q;
    logic [CHANNELS-1:0] cap_flag;
    logic [31:0]         pin_out;

    modport master (
        output sel, setctr, setfrq, setphs, rdcap, data, pin_in,
        input  phs_q, cap_q, cap_flag, pin_out
    );

    modport slave (
        input  sel, setctr, setfrq, setphs, rdcap, data, pin_in,
        output phs_q, cap_q, cap_flag, pin_out
    );
endinterface

// File: rtl/cog_ctrx.sv
// Multi-channel cog counter: NCO/duty/pin-logic/edge accumulate plus input-edge
// capture and period measurement, all in the cog clock domain.
module cog_ctrx #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned PHS_W    = 32
) (
    input  logic       clk_cog,
    input  logic       res,
    cog_ctrx_if.slave  bus
);
    localparam int unsigned SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [4:0]       r_mode [CHANNELS];
    logic [4:0]       r_bpin [CHANNELS];
    logic [4:0]       r_apin [CHANNELS];
    logic [PHS_W-1:0] r_frq  [CHANNELS];
    logic [PHS_W:0]   r_phs  [CHANNELS];
    logic [PHS_W-1:0] r_cap  [CHANNELS];
    logic [1:0]       r_dly  [CHANNELS];
    logic [CHANNELS-1:0] r_flag;

    logic [PHS_W:0]      w_sum [CHANNELS];
    logic [CHANNELS-1:0] w_hit;
    logic [CHANNELS-1:0] w_trig;
    logic [CHANNELS-1:0] w_capt;
    logic [CHANNELS-1:0] w_reload;
    logic [CHANNELS-1:0] w_outa;
    logic [CHANNELS-1:0] w_outb;
    logic [31:0]         w_pins;
    logic [PHS_W:0]      w_phs_q;
    logic [PHS_W-1:0]    w_cap_q;
    logic                w_unused_data;

    // Only a subset of the ctr bits are meaningful.
    assign w_unused_data = ^bus.data;

    // Channel select decode; an out-of-range select matches nothing.
    always_comb begin
        w_hit = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_hit[c] = (bus.sel == SW'(c));
        end
    end

    // Per-channel mode decode: trigger, capture, reload and pin drives.
    always_comb begin
        logic [3:0] lut;
        logic       rise;
        logic       fall;
        w_trig   = '0;
        w_capt   = '0;
        w_reload = '0;
        w_outa   = '0;
        w_outb   = '0;
        lut      = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_sum[c] = {1'b0, r_phs[c][PHS_W-1:0]} + {1'b0, r_frq[c]};
            lut  = r_mode[c][3:0];
            rise = (r_dly[c] == 2'b01);
            fall = (r_dly[c] == 2'b10);
            if (r_mode[c][4]) begin
                w_trig[c] = lut[r_dly[c]];
            end else begin
                case (r_mode[c][3:0])
                    4'd1: begin w_trig[c] = 1'b1; w_capt[c] = rise; end
                    4'd2: begin w_trig[c] = 1'b1; w_capt[c] = fall; end
                    4'd3: begin
                        w_trig[c]   = 1'b1;
                        w_capt[c]   = rise;
                        w_reload[c] = rise;
                    end
                    4'd4, 4'd5: begin
                        w_trig[c] = 1'b1;
                        w_outa[c] = r_phs[c][PHS_W-1];
                        w_outb[c] = r_mode[c][0] & ~r_phs[c][PHS_W-1];
                    end
                    4'd6, 4'd7: begin
                        w_trig[c] = 1'b1;
                        w_outa[c] = r_phs[c][PHS_W];
                        w_outb[c] = r_mode[c][0] & ~r_phs[c][PHS_W];
                    end
                    4'd8, 4'd9:   w_trig[c] = r_dly[c][0];
                    4'd10, 4'd11: w_trig[c] = rise;
                    4'd12, 4'd13: w_trig[c] = ~r_dly[c][0];
                    4'd14, 4'd15: w_trig[c] = fall;
                    default: ;
                endcase
                if (r_mode[c][3] && r_mode[c][0]) begin
                    w_outb[c] = ~r_dly[c][0];
                end
            end
        end
    end

    // Pin merge and read-back mux.
    always_comb begin
        w_pins  = '0;
        w_phs_q = '0;
        w_cap_q = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_pins = w_pins | (32'(w_outb[c]) << r_bpin[c]) | (32'(w_outa[c]) << r_apin[c]);
            if (w_hit[c]) begin
                w_phs_q = r_phs[c];
                w_cap_q = r_cap[c];
            end
        end
    end

    assign bus.pin_out  = w_pins;
    assign bus.phs_q    = w_phs_q;
    assign bus.cap_q    = w_cap_q;
    assign bus.cap_flag = r_flag;

    // Channel state; setphs beats reload beats trig, capture sees the pre-update phs.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            r_flag <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                r_mode[c] <= '0;
                r_bpin[c] <= '0;
                r_apin[c] <= '0;
                r_frq[c]  <= '0;
                r_phs[c]  <= '0;
                r_cap[c]  <= '0;
                r_dly[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (w_hit[c] && bus.setctr) begin
                    r_mode[c] <= bus.data[30:26];
                    r_bpin[c] <= bus.data[13:9];
                    r_apin[c] <= bus.data[4:0];
                end
                if (w_hit[c] && bus.setfrq) begin
                    r_frq[c] <= bus.data[PHS_W-1:0];
                end
                if (r_mode[c] != 5'd0) begin
                    r_dly[c][0] <= bus.pin_in[r_apin[c]];
                    r_dly[c][1] <= r_mode[c][4] ? bus.pin_in[r_bpin[c]] : r_dly[c][0];
                end
                if (w_hit[c] && bus.setphs) begin
                    r_phs[c] <= {1'b0, bus.data[PHS_W-1:0]};
                end else if (w_reload[c]) begin
                    r_phs[c] <= {1'b0, r_frq[c]};
                end else if (w_trig[c]) begin
                    r_phs[c] <= w_sum[c];
                end
                if (w_capt[c]) begin
                    r_cap[c]  <= r_phs[c][PHS_W-1:0];
                    r_flag[c] <= 1'b1;
                end else if (w_hit[c] && bus.rdcap) begin
                    r_flag[c] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cog_ctrx.sv
// Bench for cog_ctrx: table-driven NCO/duty checks plus hand-written capture,
// reset, edge-accumulate and narrow-accumulator sequences through a scoreboard.
module tb_cog_ctrx;
    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    cog_ctrx_if #(.CHANNELS(2), .PHS_W(32)) bus ();
    cog_ctrx_if #(.CHANNELS(2), .PHS_W(8))  bus8 ();

    cog_ctrx #(.CHANNELS(2), .PHS_W(32)) u_dut  (.clk_cog(clk), .res(res), .bus(bus));
    cog_ctrx #(.CHANNELS(2), .PHS_W(8))  u_dut8 (.clk_cog(clk), .res(res), .bus(bus8));

    localparam int K_PHS = 0, K_CAP = 1, K_FLAG = 2, K_PIN = 3, K_PHS8 = 4, K_PIN8 = 5;
    localparam int R_CTR = 0, R_FRQ = 1, R_PHS = 2;

    typedef struct { string nm; int kind; logic [63:0] val; } exp_t;
    typedef struct { logic [31:0] pin_in; logic [32:0] phs; logic [31:0] pin; } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    vec_t nco_v[8];
    vec_t duty_v[4];

    function automatic logic [63:0] observe(input int kind);
        if (kind == K_PHS)       return 64'(bus.phs_q);
        else if (kind == K_CAP)  return 64'(bus.cap_q);
        else if (kind == K_FLAG) return 64'(bus.cap_flag);
        else if (kind == K_PIN)  return 64'(bus.pin_out);
        else if (kind == K_PHS8) return 64'(bus8.phs_q);
        else                     return 64'(bus8.pin_out);
    endfunction

    task automatic push_exp(input string nm, input int kind, input logic [63:0] val);
        exp_t e;
        e.nm = nm; e.kind = kind; e.val = val;
        sb.push_back(e);
    endtask

    // One clock; everything queued for this cycle is checked just after the edge.
    task automatic step();
        exp_t e;
        logic [63:0] act;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = observe(e.kind);
            total++;
            if (act !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.nm, act, e.val);
            end
        end
    endtask

    task automatic wr(input int dut, input int r, input logic [31:0] d, input logic sl);
        if (dut == 0) begin
            bus.sel = sl; bus.data = d;
            bus.setctr = (r == R_CTR); bus.setfrq = (r == R_FRQ); bus.setphs = (r == R_PHS);
        end else begin
            bus8.sel = sl; bus8.data = d;
            bus8.setctr = (r == R_CTR); bus8.setfrq = (r == R_FRQ); bus8.setphs = (r == R_PHS);
        end
        step();
        bus.setctr = 0;  bus.setfrq = 0;  bus.setphs = 0;
        bus8.setctr = 0; bus8.setfrq = 0; bus8.setphs = 0;
    endtask

    task automatic push_all_zero(input string nm);
        push_exp({nm, "_phs"},  K_PHS,  64'h0);
        push_exp({nm, "_cap"},  K_CAP,  64'h0);
        push_exp({nm, "_flag"}, K_FLAG, 64'h0);
        push_exp({nm, "_pin"},  K_PIN,  64'h0);
    endtask

    initial begin
        nco_v[0] = '{32'h0, 33'h0_4000_0000, 32'h00};
        nco_v[1] = '{32'h0, 33'h0_8000_0000, 32'h20};
        nco_v[2] = '{32'h0, 33'h0_C000_0000, 32'h20};
        nco_v[3] = '{32'h0, 33'h1_0000_0000, 32'h00};
        nco_v[4] = '{32'h0, 33'h0_4000_0000, 32'h00};
        nco_v[5] = '{32'h0, 33'h0_8000_0000, 32'h20};
        nco_v[6] = '{32'h0, 33'h0_C000_0000, 32'h20};
        nco_v[7] = '{32'h0, 33'h1_0000_0000, 32'h00};
        duty_v[0] = '{32'h0, 33'h0_8000_0000, 32'h0};
        duty_v[1] = '{32'h0, 33'h1_0000_0000, 32'h8};
        duty_v[2] = '{32'h0, 33'h0_8000_0000, 32'h0};
        duty_v[3] = '{32'h0, 33'h1_0000_0000, 32'h8};

        bus.sel = 0; bus.setctr = 0; bus.setfrq = 0; bus.setphs = 0; bus.rdcap = 0;
        bus.data = 0; bus.pin_in = 0;
        bus8.sel = 0; bus8.setctr = 0; bus8.setfrq = 0; bus8.setphs = 0; bus8.rdcap = 0;
        bus8.data = 0; bus8.pin_in = 0;
        res = 1'b1;
        step();
        push_all_zero("reset");
        step();
        res = 1'b0;

        // NCO single on ch0, pin 5, quarter-turn per cycle.
        wr(0, R_FRQ, 32'h4000_0000, 1'b0);
        push_exp("nco_start_phs", K_PHS, 64'h0);
        push_exp("nco_start_pin", K_PIN, 64'h0);
        wr(0, R_CTR, 32'h1000_0005, 1'b0);
        for (int k = 0; k < 8; k++) begin
            bus.pin_in = nco_v[k].pin_in;
            push_exp($sformatf("nco_phs_%0d", k), K_PHS, 64'(nco_v[k].phs));
            push_exp($sformatf("nco_pin_%0d", k), K_PIN, 64'(nco_v[k].pin));
            step();
        end

        // Duty single on ch1, pin 3, half-turn per cycle.
        wr(0, R_CTR, 32'h0, 1'b0);
        wr(0, R_FRQ, 32'h8000_0000, 1'b1);
        wr(0, R_PHS, 32'h0, 1'b1);
        push_exp("duty_start_pin", K_PIN, 64'h0);
        wr(0, R_CTR, 32'h1800_0003, 1'b1);
        for (int k = 0; k < 4; k++) begin
            bus.pin_in = duty_v[k].pin_in;
            push_exp($sformatf("duty_phs_%0d", k), K_PHS, 64'(duty_v[k].phs));
            push_exp($sformatf("duty_pin_%0d", k), K_PIN, 64'(duty_v[k].pin));
            step();
        end

        // Period measurement on ch0, square wave of period 10 on pin 7.
        wr(0, R_CTR, 32'h0, 1'b1);
        wr(0, R_FRQ, 32'h1, 1'b0);
        wr(0, R_CTR, 32'h0C00_0007, 1'b0);
        bus.sel = 0;
        for (int i = 0; i < 40; i++) begin
            bus.pin_in = ((i % 10) < 5) ? 32'h80 : 32'h0;
            bus.rdcap  = (i == 12) || (i == 21);
            if (i == 11) begin
                push_exp("per_cap_11", K_CAP, 64'd10);
                push_exp("per_flag_11", K_FLAG, 64'h1);
                push_exp("per_reload_phs", K_PHS, 64'h1);
            end
            if (i == 12) push_exp("per_rdcap_clr", K_FLAG, 64'h0);
            if (i == 15) push_exp("per_phs_15", K_PHS, 64'd5);
            if (i == 20) push_exp("per_flag_20", K_FLAG, 64'h0);
            if (i == 21) begin
                push_exp("per_set_beats_rd", K_FLAG, 64'h1);
                push_exp("per_cap_21", K_CAP, 64'd10);
            end
            if (i == 31) push_exp("per_cap_31", K_CAP, 64'd10);
            step();
        end
        bus.rdcap = 0;

        // Reset mid-operation, then no capture until a mode is written again.
        res = 1'b1;
        bus.pin_in = 32'h80;
        push_all_zero("midres");
        step();
        res = 1'b0;
        for (int i = 40; i < 60; i++) begin
            bus.pin_in = ((i % 10) < 5) ? 32'h80 : 32'h0;
            if (i == 59) push_all_zero("postres");
            step();
        end

        // Pos-edge accumulate on ch0, pin 2, frq 3.
        bus.pin_in = 0;
        wr(0, R_FRQ, 32'h3, 1'b0);
        wr(0, R_PHS, 32'h0, 1'b0);
        wr(0, R_CTR, 32'h2800_0002, 1'b0);
        bus.sel  = 0;
        bus.data = 32'h100;
        for (int i = 0; i < 13; i++) begin
            bus.pin_in = (i < 8 && (i % 2) == 0) || (i == 10) ? 32'h4 : 32'h0;
            bus.setphs = (i == 11);
            if (i == 7)  push_exp("pose_phs_4edges", K_PHS, 64'd12);
            if (i == 9) begin
                push_exp("pose_phs_hold", K_PHS, 64'd12);
                push_exp("pose_pin_none", K_PIN, 64'h0);
            end
            if (i == 11) push_exp("pose_setphs_wins", K_PHS, 64'h100);
            if (i == 12) push_exp("pose_after_set", K_PHS, 64'h100);
            step();
        end
        bus.setphs = 0;

        // Narrow accumulator wrap with carry.
        wr(1, R_FRQ, 32'hFF, 1'b0);
        wr(1, R_PHS, 32'h02, 1'b0);
        push_exp("w8_start", K_PHS8, 64'h002);
        wr(1, R_CTR, 32'h1000_0000, 1'b0);
        push_exp("w8_carry", K_PHS8, 64'h101);
        push_exp("w8_pin_lo", K_PIN8, 64'h0);
        step();
        push_exp("w8_wrap", K_PHS8, 64'h100);
        step();
        push_exp("w8_next", K_PHS8, 64'h0FF);
        push_exp("w8_pin_hi", K_PIN8, 64'h1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cog_ctrx.md
# cog_ctrx

Parametrised multi-channel cog counter: CHANNELS independent counter channels, each holding a mode word, frequency and phase accumulator, plus a capture register. It retains NCO, duty, pin-logic and edge-accumulate behaviour and adds input-edge capture and period measurement. All logic runs in the cog clock domain, with no PLL. It sits beside the cog ALU: the ALU writes channel registers and reads phase and capture values back; channel pin outputs are OR-merged onto the cog's output pin bus.

## Interface
- CHANNELS, 2: number of counter channels, 1..8.
- PHS_W, 32: accumulator width, 8..32. The `data` bus is truncated to its low PHS_W bits for frq/phs writes.
- SW: $clog2(CHANNELS), minimum 1. Channel-select width.
- clk_cog  in  1  cog clock; all state updates on its rising edge.
- res  in  1  synchronous, active-high reset.
- sel  in  SW  channel addressed by set*/rdcap strobes and by read outputs.
- setctr / setfrq / setphs  in  1 each  write `data` to the selected channel's ctr/frq/phs.
- rdcap  in  1  acknowledge: clears the selected channel's cap_flag.
- data  in  32  write data.
- pin_in  in  32  input pins.
- phs_q  out  PHS_W+1  selected channel's {carry, phs}; combinational mux.
- cap_q  out  PHS_W  selected channel's capture register.
- cap_flag  out  CHANNELS  per-channel capture-pending flags.
- pin_out  out  32  OR of all channels' outa/outb pin drives.

## Operation
- Per-channel ctr fields: mode = ctr[30:26], bpin = ctr[13:9], apin = ctr[4:0]. Other bits are stored but ignored. An out-of-range `sel` (≥ CHANNELS) makes writes no-ops and reads return 0.
- dly[1:0] updates every cycle when mode ≠ 0: dly[0] ← pin_in[apin]; dly[1] ← mode[4] ? pin_in[bpin] : old dly[0]. A rising edge is dly==01; a falling edge is dly==10.
- Accumulate (trig): phs ← {1'b0, phs[PHS_W-1:0]} + {1'b0, frq}. The carry lands in phs[PHS_W].
- Modes:
  - 00000 off: no trig, no outputs.
  - 00001 capture-rise: trig every cycle; on a rising edge, cap ← phs[PHS_W-1:0] and cap_flag set.
  - 00010 capture-fall: same as capture-rise, but on a falling edge.
  - 00011 period: trig every cycle; on a rising edge, cap ← phs and phs ← {1'b0, frq} (reload replaces accumulate), cap_flag set.
  - 00100 NCO single: trig always, outa = phs[PHS_W-1].
  - 00101 NCO differential: as 00100, plus outb = !outa.
  - 00110 duty single: trig always, outa = phs[PHS_W].
  - 00111 duty differential: as 00110, plus outb = !outa.
  - 01000..01111: pos, pos w/fb, pos edge, pos edge w/fb, neg, neg w/fb, neg edge, neg edge w/fb.
    - trig is dly[0], dly[0], dly==01, dly==01, !dly[0], !dly[0], dly==10, dly==10 respectively.
    - "w/fb" modes also drive outb = !dly[0].
  - 1xxxx logic: trig = mode[3:0][dly]; no outputs.
- pin_out = OR over channels of (outb << bpin) | (outa << apin).
- Priority within a channel: setphs > period reload > trig. The capture always samples the pre-update phs, including when setphs or reload happens in the same cycle.
- cap_flag: set wins over rdcap in the same cycle. A capture while the flag is already set overwrites cap (overrun is not recorded).
- setctr changing mode does not clear phs, frq, cap or dly.

## Timing
- Reset (res high at an edge): ctr, frq, phs, cap, dly and cap_flag all become 0. pin_out = 0, phs_q = 0, cap_q = 0 from the following cycle.
- Register writes are visible on phs_q/cap_q and take effect in mode logic one cycle after the strobe edge.
- Pin-to-action latency: pin_in sampled at edge n enters dly[0]; edge or trig action is applied at edge n+1.
- Accumulation wraps modulo 2^PHS_W. phs[PHS_W] is the carry of the last add and is cleared by setphs or reload.
- Outputs derive combinationally from registered state and have no reset-released glitch.

## Test plan
- PHS_W=32, ch0 NCO single (ctr=0x10000005), frq=0x40000000 → pin_out[5] toggles every 2 cycles (period 4). ch1 off → no other bits set.
- Duty single on ch1, apin=3, frq=0x80000000, phs=0 → carry set every other cycle; pin_out[3] has a 50% pattern and phs_q alternates 0x0_80000000 / 0x1_00000000.
- Period mode, frq=1, square wave on pin 7 with period 10 → cap_q=10 after each rising edge from the second edge on; cap_flag[0] set; rdcap clears it; simultaneous edge+rdcap leaves the flag at 1.
- Pos-edge mode, frq=3, 4 rising edges on the apin → phs_q=12. setphs coincident with an edge → phs=data (not data+3).
- PHS_W=8, frq=0xFF from phs=0x02 → phs_q=0x101, and the next cycle 0x100 (wrap, carry).
- Assert res mid-operation (period mode, flag set) → next cycle every output is 0, and no capture occurs until a new mode is written.
